// File: rtl/hex_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_arbiter
// Brief    : Round-robin nibble writes into a digit register file, with a
//            refresh scanner that time-shares one external 7-segment decoder.
//            Optional macro HEX_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int NUM_DIGITS  = 6,
    parameter int REFRESH_DIV = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [3*NUM_REQ-1:0]    wr_digit,
    input  logic [4*NUM_REQ-1:0]    wr_data,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    wr_err,
    output logic [3:0]              dec_data,
    input  logic [6:0]              dec_seg,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    frame_done
);

    localparam int c_REQ_W = $clog2(NUM_REQ);
    localparam int c_DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_DIV_W = $clog2(REFRESH_DIV + 1);

    logic [3:0]         r_digit [NUM_DIGITS];
    logic [6:0]         r_seg   [NUM_DIGITS];
    logic [c_REQ_W-1:0] r_rr_ptr;
    logic [c_DIG_W-1:0] r_scan_idx;
    logic [c_DIV_W-1:0] r_div_cnt;

    logic [2:0]         w_req_digit [NUM_REQ];
    logic [3:0]         w_req_data  [NUM_REQ];
    logic [c_REQ_W-1:0] w_idx       [NUM_REQ];
    logic [c_REQ_W-1:0] w_win;
    logic               w_any;
    logic [2:0]         w_win_digit;
    logic [3:0]         w_win_data;
    logic               w_oor;
    logic               w_cap;
    logic               w_last;
    logic [6:0]         w_cap_seg;

    // w_idx[k] is the requester examined k-th in priority order from r_rr_ptr
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
            logic [c_REQ_W:0] w_sum;
            assign w_req_digit[g] = wr_digit[3*g +: 3];
            assign w_req_data[g]  = wr_data[4*g +: 4];
            assign w_sum          = {1'b0, r_rr_ptr} + (c_REQ_W+1)'(g);
            assign w_idx[g]       = (w_sum >= (c_REQ_W+1)'(NUM_REQ)) ?
                                    c_REQ_W'(w_sum - (c_REQ_W+1)'(NUM_REQ)) :
                                    w_sum[c_REQ_W-1:0];
        end
    endgenerate

    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[w_idx[k]]) begin
                w_win = w_idx[k];
                w_any = 1'b1;
            end
        end
    end

    assign w_win_digit = w_req_digit[w_win];
    assign w_win_data  = w_req_data[w_win];
    assign w_oor       = ({1'b0, w_win_digit} >= 4'(NUM_DIGITS));

    assign dec_data = r_digit[r_scan_idx];
    assign w_cap    = (r_div_cnt == c_DIV_W'(REFRESH_DIV - 1));
    assign w_last   = (r_scan_idx == c_DIG_W'(NUM_DIGITS - 1));

`ifdef HEX_LEADING_ZERO_BLANK_EN
    logic [c_DIG_W-1:0] w_hi_nz;

    always_comb begin
        w_hi_nz = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_digit[d] != 4'd0) w_hi_nz = c_DIG_W'(d);
        end
    end

    // Digit 0 is never above w_hi_nz, so an all-zero value still shows "0"
    assign w_cap_seg = (r_scan_idx > w_hi_nz) ? 7'h7F : dec_seg;
`else
    assign w_cap_seg = dec_seg;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr <= '0;
            grant    <= '0;
            wr_err   <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) r_digit[d] <= 4'd0;
        end else begin
            grant  <= '0;
            wr_err <= 1'b0;
            if (w_any) begin
                grant[w_win] <= 1'b1;
                wr_err       <= w_oor;
                r_rr_ptr     <= (w_win == c_REQ_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    if (!w_oor && w_win_digit == 3'(d)) r_digit[d] <= w_win_data;
                end
            end
        end
    end

    // Capture reads dec_seg from pre-edge registers, so a colliding write shows next pass
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scan_idx <= '0;
            r_div_cnt  <= '0;
            frame_done <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) r_seg[d] <= 7'h7F;
        end else begin
            frame_done <= w_cap && w_last;
            if (w_cap) begin
                r_div_cnt  <= '0;
                r_scan_idx <= w_last ? '0 : r_scan_idx + 1'b1;
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    if (r_scan_idx == c_DIG_W'(d)) r_seg[d] <= w_cap_seg;
                end
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex
            assign hex_out[7*g +: 7] = r_seg[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_hex_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_arbiter
// Brief    : Directed bench for hex_display_arbiter with an external decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_arbiter;

`ifdef HEX_LEADING_ZERO_BLANK_EN
    localparam bit c_LZB = 1'b1;
`else
    localparam bit c_LZB = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [11:0] wr_digit = '0;
    logic [15:0] wr_data = '0;
    logic [3:0]  grant;
    logic        wr_err;
    logic [3:0]  dec_data;
    logic [6:0]  dec_seg;
    logic [41:0] hex_out;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    hex_display_arbiter #(.NUM_REQ(4), .NUM_DIGITS(6), .REFRESH_DIV(4)) dut (
        .clock(clock), .reset(reset), .req(req), .wr_digit(wr_digit),
        .wr_data(wr_data), .grant(grant), .wr_err(wr_err), .dec_data(dec_data),
        .dec_seg(dec_seg), .hex_out(hex_out), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
        endcase
    endfunction

    assign dec_seg = seg7(dec_data);

    typedef struct {
        logic [3:0]  req;
        logic [11:0] wr_digit;
        logic [15:0] wr_data;
        logic [3:0]  exp_grant;
        logic        exp_err;
    } vec_t;

    vec_t vec [11];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [6:0] digit(input int d);
        return hex_out[7*d +: 7];
    endfunction

    initial begin
        int fd_cnt;
        logic [6:0] idle_exp;

        vec[0]  = '{4'b0100, {3'd0, 3'd3, 3'd0, 3'd0}, 16'h0500, 4'b0100, 1'b0};
        vec[1]  = '{4'b0000, 12'd0,                    16'h0000, 4'b0000, 1'b0};
        vec[2]  = '{4'b1111, {3'd4, 3'd2, 3'd1, 3'd0}, 16'h7621, 4'b1000, 1'b0};
        vec[3]  = '{4'b1111, {3'd4, 3'd2, 3'd1, 3'd0}, 16'h7621, 4'b0001, 1'b0};
        vec[4]  = '{4'b1111, {3'd4, 3'd2, 3'd1, 3'd0}, 16'h7621, 4'b0010, 1'b0};
        vec[5]  = '{4'b1111, {3'd4, 3'd2, 3'd1, 3'd0}, 16'h7621, 4'b0100, 1'b0};
        vec[6]  = '{4'b1111, {3'd4, 3'd2, 3'd1, 3'd0}, 16'h7621, 4'b1000, 1'b0};
        vec[7]  = '{4'b0010, {3'd0, 3'd0, 3'd7, 3'd0}, 16'h00F0, 4'b0010, 1'b1};
        vec[8]  = '{4'b1010, {3'd4, 3'd0, 3'd7, 3'd0}, 16'h70F0, 4'b1000, 1'b0};
        vec[9]  = '{4'b1010, {3'd4, 3'd0, 3'd7, 3'd0}, 16'h70F0, 4'b0010, 1'b1};
        vec[10] = '{4'b0000, 12'd0,                    16'h0000, 4'b0000, 1'b0};

        // Reset state and one idle frame
        apply_reset();
        check("rst_hex", hex_out, {6{7'h7F}});
        check("rst_grant", grant, 4'b0);
        check("rst_err", wr_err, 1'b0);
        check("rst_frame", frame_done, 1'b0);
        check("rst_dec", dec_data, 4'h0);
        fd_cnt = 0;
        for (int t = 1; t <= 25; t++) begin
            tick();
            if (t <= 24 && frame_done) fd_cnt++;
            if (t == 20) check("idle_d5_blank", digit(5), 7'h7F);
            if (t == 24) begin
                check("frame_done_24", frame_done, 1'b1);
                for (int d = 0; d < 6; d++) begin
                    idle_exp = (c_LZB && d > 0) ? 7'h7F : 7'h40;
                    check($sformatf("idle_d%0d", d), digit(d), idle_exp);
                end
            end
            if (t == 25) check("frame_done_25", frame_done, 1'b0);
        end
        check("frame_done_count", fd_cnt, 1);

        // Reset overrides pending requests
        reset = 1'b1;
        req = 4'b1111;
        tick();
        check("rst_mid_grant", grant, 4'b0);
        apply_reset();

        // Arbitration table
        for (int i = 0; i < 11; i++) begin
            req      = vec[i].req;
            wr_digit = vec[i].wr_digit;
            wr_data  = vec[i].wr_data;
            tick();
            check($sformatf("grant_v%0d", i), grant, vec[i].exp_grant);
            check($sformatf("err_v%0d", i), wr_err, vec[i].exp_err);
        end
        req = '0;
        for (int t = 0; t < 25; t++) tick();
        check("arb_d0", digit(0), 7'h79);
        check("arb_d1", digit(1), 7'h24);
        check("arb_d2", digit(2), 7'h02);
        check("arb_d3", digit(3), 7'h12);
        check("arb_d4", digit(4), 7'h78);
        check("arb_d5", digit(5), c_LZB ? 7'h7F : 7'h40);

        // Write to digit 0 on its own capture edge
        apply_reset();
        tick(); tick(); tick();
        req = 4'b0001; wr_digit = 12'd0; wr_data = 16'h000A;
        tick();
        check("coll_grant", grant, 4'b0001);
        check("coll_old", digit(0), 7'h40);
        req = '0;
        for (int t = 0; t < 23; t++) tick();
        check("coll_before", digit(0), 7'h40);
        tick();
        check("coll_new", digit(0), 7'h08);

        // Single nonzero digit at index 4
        apply_reset();
        req = 4'b0001; wr_digit = {3'd0, 3'd0, 3'd0, 3'd4}; wr_data = 16'h0001;
        tick();
        check("lz_grant", grant, 4'b0001);
        req = '0;
        for (int t = 0; t < 25; t++) tick();
        for (int d = 0; d < 4; d++) check($sformatf("lz_d%0d", d), digit(d), 7'h40);
        check("lz_d4", digit(4), 7'h79);
        check("lz_d5", digit(5), c_LZB ? 7'h7F : 7'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_display_arbiter.md
Name: hex_display_arbiter

Overview:
- Shares one external combinational hex-to-7-segment decoder (4-bit data in, 7-bit active-low segments out) among six HEX digit outputs.
- Arbitrates nibble writes from several requesters into a 6-entry digit register file using round-robin.
- A refresh scanner time-multiplexes the shared decoder across digits and latches each decoded pattern into a per-digit segment register.
- Sits between counter/datapath blocks (requesters) and the board HEX0..HEX5 pins.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8).
- NUM_DIGITS, 6, number of display digits and digit registers (1..8).
- REFRESH_DIV, 4, clock cycles spent on each digit per scan slot (>=1).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request; level, held until grant seen.
- wr_digit  in  3*NUM_REQ  target digit index, requester i in bits [3i+2:3i].
- wr_data  in  4*NUM_REQ  nibble to write, requester i in bits [4i+3:4i].
- grant  out  NUM_REQ  one-hot, one-cycle pulse: requester's write committed.
- wr_err  out  1  one-cycle pulse with grant when granted wr_digit >= NUM_DIGITS.
- dec_data  out  4  nibble driven to the shared decoder.
- dec_seg  in  7  decoder result for dec_data, same cycle, active-low.
- hex_out  out  7*NUM_DIGITS  digit d segments in bits [7d+6:7d], active-low (bit0=a ... bit6=g).
- frame_done  out  1  one-cycle pulse when the scan wraps from the last digit to 0.

Behaviour:
- Reset (synchronous, active-high): digit_reg all 0; hex_out all 7'h7F (blank); grant 0; wr_err 0; frame_done 0; scan_idx 0; div_cnt 0; rr_ptr 0.
- Reset asserted mid-operation overrides everything on that edge. Any in-flight request is not granted and must stay high to be served after reset.
- Arbitration, evaluated every edge when any req bit is high:
  - Winner is the first set req bit searching upward from rr_ptr, wrapping.
  - On that edge: digit_reg[wr_digit_w] <= wr_data_w; grant <= one-hot(w); rr_ptr <= (w+1) mod NUM_REQ.
  - Exactly one grant per cycle; grant is low on cycles with no request.
- Request protocol:
  - Requester drops req in the cycle it sees grant.
  - req still high during its grant cycle counts as a new request, and its data is sampled again on that edge.
  - Round-robin bounds wait to NUM_REQ-1 grants.
- Out-of-range write: if wr_digit_w >= NUM_DIGITS, no register is written; grant still pulses and wr_err pulses with it.
- Refresh scanner:
  - dec_data = digit_reg[scan_idx], combinational from registers.
  - div_cnt counts 0..REFRESH_DIV-1.
  - On the edge where div_cnt == REFRESH_DIV-1: seg_reg[scan_idx] <= dec_seg; div_cnt <= 0; scan_idx <= scan_idx+1, wrapping to 0 after NUM_DIGITS-1.
  - frame_done pulses in the cycle after the capture of digit NUM_DIGITS-1.
- Write/capture collision: if a write targets scan_idx on the capture edge, the capture uses the pre-write value. The new value appears on the next pass.
- Latency, write commit to hex_out update:
  - Minimum 1 cycle after the commit edge.
  - Maximum NUM_DIGITS*REFRESH_DIV cycles.
- Frame period is exactly NUM_DIGITS*REFRESH_DIV cycles; the first full display is valid after one frame from reset.
- All arithmetic is unsigned. rr_ptr and scan_idx wrap modulo NUM_REQ and NUM_DIGITS; no illegal counter states are reachable.

Optional Feature:
- Macro: HEX_LEADING_ZERO_BLANK_EN.
- Defined: at capture, if scan_idx > index of the highest nonzero digit_reg, seg_reg[scan_idx] <= 7'h7F instead of dec_seg. Digit 0 is never blanked, so all-zero shows a single "0". The highest-nonzero index is computed combinationally from the current digit_reg.
- Undefined: every digit always shows its decoded value, zeros included.

Test Plan:
- Reset, then idle 24 cycles (defaults) -> hex_out = 7'h7F for all digits before the first capture of each digit. After one frame all digits = 7'h40 ("0"). frame_done pulses once at cycle 24.
- req[2] only, wr_digit=3, wr_data=5 -> grant=4'b0100 for 1 cycle. Within 24 cycles hex_out[27:21] = 7'h12; other digits unchanged.
- req=4'b1111 held continuously, distinct digits -> grants in order 0,1,2,3,0,... one per cycle. No requester is skipped.
- req[1] with wr_digit=7 -> grant[1] and wr_err pulse together; all hex_out unchanged after a full frame.
- Write digit 0 = 4'hA exactly on digit 0's capture edge -> that frame captures the old value; the next frame shows 7'h08.
- With HEX_LEADING_ZERO_BLANK_EN and digits {0,0,0,0,1,0}, index 4 = 1, others 0 -> digit 5 = 7'h7F, digits 0..3 = 7'h40, digit 4 = 7'h79. Without the macro, digit 5 = 7'h40.
